// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
// ------------------
// Direct-mapped, read-only instruction cache controller between the CPU fetch
// port and a burst-read memory bus. Every fetch is looked up against the
// internal valid/tag arrays. A hit returns the stored word. A miss fetches the
// whole line as a WPL-beat burst, fills the line, and then returns the
// requested word.
//
// Optional feature: define ICACHE_STATS_EN to add the saturating hit_cnt and
// miss_cnt outputs.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   cpu_req      fetch request, held high until cpu_ready
//   cpu_addr     byte address (bits [1:0] ignored), stable while cpu_req is high
//   cpu_rdata    fetched word, valid when cpu_ready=1
//   cpu_ready    one-cycle completion pulse
//   flush        invalidate all lines (deferred to the next IDLE cycle if busy)
//   mem_req      burst read request, held high until mem_gnt
//   mem_addr     line-aligned burst address
//   mem_gnt      burst request accepted
//   mem_rvalid   burst beat valid
//   mem_rdata    burst beat data, ascending word order
//   hit_cnt      (ICACHE_STATS_EN) saturating lookup-hit count
//   miss_cnt     (ICACHE_STATS_EN) saturating lookup-miss count
module icache_refill_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int BLKIDX_BIT   = 4,
  parameter int WORD_OFF_BIT = 2,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int LINES  = 1 << BLKIDX_BIT;
  localparam int WPL    = 1 << WORD_OFF_BIT;
  localparam int IDX_LO = WORD_OFF_BIT + 2;
  localparam int TAG_LO = IDX_LO + BLKIDX_BIT;
  localparam int TAG_W  = ADDR_WIDTH - TAG_LO;

  localparam logic [WORD_OFF_BIT-1:0] CNT_LAST = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    REQ    = 3'd2,
    FILL   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t state, next_state;

  // Cache storage; tag and data arrays carry no reset.
  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_mem  [0:LINES-1];
  logic [DATA_WIDTH-1:0] data_mem [0:LINES*WPL-1];

  // Latched request word address; byte-lane bits are never used.
  logic [ADDR_WIDTH-1:2]   req_addr;
  logic [WORD_OFF_BIT-1:0] req_off;
  logic [BLKIDX_BIT-1:0]   req_idx;
  logic [TAG_W-1:0]        req_tag;

  logic [WORD_OFF_BIT-1:0] cnt;
  logic                    flush_pend;
  logic                    hit;

  // Per-cycle action strobes decoded from the current state.
  logic latch_req;
  logic do_flush;
  logic lookup_hit;
  logic lookup_miss;
  logic gnt_take;
  logic fill_beat;
  logic fill_last;
  logic resp;

  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign req_off = req_addr[IDX_LO-1:2];
  assign req_idx = req_addr[TAG_LO-1:IDX_LO];
  assign req_tag = req_addr[ADDR_WIDTH-1:TAG_LO];
  assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);

`ifdef ICACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    latch_req   = 1'b0;
    do_flush    = 1'b0;
    lookup_hit  = 1'b0;
    lookup_miss = 1'b0;
    gnt_take    = 1'b0;
    fill_beat   = 1'b0;
    fill_last   = 1'b0;
    resp        = 1'b0;
    case (state)
      IDLE: begin
        // The CPU still holds cpu_req during the cpu_ready cycle, so a
        // request is only accepted once the pulse has gone away.
        if (flush || flush_pend) begin
          do_flush = 1'b1;
        end else if (cpu_req && !cpu_ready) begin
          latch_req  = 1'b1;
          next_state = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          lookup_hit = 1'b1;
          next_state = IDLE;
        end else begin
          lookup_miss = 1'b1;
          next_state  = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          gnt_take   = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        if (mem_rvalid) begin
          fill_beat = 1'b1;
          if (cnt == CNT_LAST) begin
            fill_last  = 1'b1;
            next_state = RESP;
          end
        end
      end
      RESP: begin
        resp       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Control and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      if (state == IDLE)  flush_pend <= 1'b0;
      else if (flush)     flush_pend <= 1'b1;

      // A line is invalid from the moment its refill starts, so a partially
      // filled line can never hit.
      if (do_flush)         valid          <= '0;
      else if (lookup_miss) valid[req_idx] <= 1'b0;
      else if (fill_last)   valid[req_idx] <= 1'b1;

      if (gnt_take)       cnt <= '0;
      else if (fill_beat) cnt <= cnt + 1'b1;

      cpu_ready <= lookup_hit | resp;
      if (lookup_hit || resp) cpu_rdata <= data_mem[{req_idx, req_off}];

      if (lookup_miss) begin
        mem_req  <= 1'b1;
        mem_addr <= {req_tag, req_idx, {(WORD_OFF_BIT + 2){1'b0}}};
      end else if (gnt_take) begin
        mem_req <= 1'b0;
      end
    end
  end

  // Datapath storage
  always_ff @(posedge clk) begin
    if (latch_req) req_addr <= cpu_addr[ADDR_WIDTH-1:2];
    if (fill_beat) data_mem[{req_idx, cnt}] <= mem_rdata;
    if (fill_last) tag_mem[req_idx] <= req_tag;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lookup_hit)  hit_cnt  <= sat_inc(hit_cnt);
      if (lookup_miss) miss_cnt <= sat_inc(miss_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed testbench for icache_refill_ctrl: cold miss, hit, conflict
// eviction, flush in IDLE, flush during a refill, and reset mid-refill.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete fetch. The bench acts as both CPU and memory: it grants
  // mem_req immediately and returns beats base+0 .. base+3 on consecutive
  // cycles. flush_beat / rst_beat select the beat during which flush is
  // pulsed / reset is asserted instead of the beat (-1 for neither).
  task automatic fetch(input logic [31:0] addr, input bit exp_miss,
                       input logic [31:0] exp_maddr, input logic [31:0] base,
                       input logic [31:0] exp_rdata, input int flush_beat,
                       input int rst_beat, input string name);
    int          cyc;
    int          beat;
    bit          granted;
    bit          got_ready;
    bit          aborted;
    bit          saw_req;
    logic [31:0] maddr;
    logic [31:0] rdata;
    int          lat;
    cyc = 0; beat = 0; granted = 0; got_ready = 0; aborted = 0;
    saw_req = 0; maddr = '0; rdata = '0; lat = 0;
    @(posedge clk); #1;
    cpu_req  = 1'b1;
    cpu_addr = addr;
    while (!got_ready && !aborted && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      flush      = 1'b0;
      if (cpu_ready) begin
        got_ready = 1;
        lat       = cyc;
        rdata     = cpu_rdata;
      end else if (mem_req) begin
        saw_req = 1;
        maddr   = mem_addr;
        if (!granted) begin
          mem_gnt = 1'b1;
          granted = 1;
        end
      end else if (granted && beat < 4) begin
        if (beat == rst_beat) begin
          rst     = 1'b1;
          cpu_req = 1'b0;
          aborted = 1;
        end else begin
          mem_rvalid = 1'b1;
          mem_rdata  = base + 32'(beat);
          if (beat == flush_beat) flush = 1'b1;
          beat++;
        end
      end
    end
    check({name, " miss"}, 32'(saw_req), 32'(exp_miss));
    if (exp_miss) check({name, " mem_addr"}, maddr, exp_maddr);
    if (aborted) begin
      @(posedge clk); #1;
      rst = 1'b0;
      check({name, " rst mem_req"}, 32'(mem_req), 32'd0);
      check({name, " rst cpu_ready"}, 32'(cpu_ready), 32'd0);
    end else begin
      check({name, " ready seen"}, 32'(got_ready), 32'd1);
      check({name, " latency"}, 32'(lat), exp_miss ? 32'd8 : 32'd2);
      check({name, " rdata"}, rdata, exp_rdata);
      // cpu_req stays high through the ready cycle, as a real fetch unit
      // would; it must not start a second transaction.
      @(posedge clk); #1;
      cpu_req = 1'b0;
      check({name, " ready pulse 1"}, 32'(cpu_ready), 32'd0);
      @(posedge clk); #1;
      check({name, " no re-req ready"}, 32'(cpu_ready), 32'd0);
      check({name, " no re-req mem"}, 32'(mem_req), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    cpu_req    = 1'b0;
    cpu_addr   = '0;
    flush      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset cpu_ready", 32'(cpu_ready), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset cpu_rdata", cpu_rdata, 32'd0);
`ifdef ICACHE_STATS_EN
    check("reset hit_cnt", hit_cnt, 32'd0);
    check("reset miss_cnt", miss_cnt, 32'd0);
`endif

    fetch(32'h0000_0104, 1'b1, 32'h0000_0100, 32'hA0, 32'hA1, -1, -1, "cold miss 104");
    fetch(32'h0000_010C, 1'b0, 32'h0,         32'h0,  32'hA3, -1, -1, "hit 10c");
    fetch(32'h0000_0504, 1'b1, 32'h0000_0500, 32'hB0, 32'hB1, -1, -1, "conflict 504");
    fetch(32'h0000_0104, 1'b1, 32'h0000_0100, 32'hA0, 32'hA1, -1, -1, "evicted 104");
    fetch(32'h0000_0100, 1'b0, 32'h0,         32'h0,  32'hA0, -1, -1, "hit 100");

    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    fetch(32'h0000_0100, 1'b1, 32'h0000_0100, 32'hC0, 32'hC0, -1, -1, "post-flush 100");
`ifdef ICACHE_STATS_EN
    check("stats hit_cnt", hit_cnt, 32'd2);
    check("stats miss_cnt", miss_cnt, 32'd4);
`endif

    fetch(32'h0000_02A8, 1'b1, 32'h0000_02A0, 32'hD0, 32'hD2, 2, -1, "flush in fill 2a8");
    fetch(32'h0000_02A8, 1'b1, 32'h0000_02A0, 32'hE0, 32'hE2, -1, -1, "after fill flush 2a8");

    fetch(32'h0000_03C4, 1'b1, 32'h0000_03C0, 32'hF0, 32'h0, -1, 2, "rst in fill 3c4");
    // Stray beats after the abort must be ignored.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("late beats mem_req", 32'(mem_req), 32'd0);
    check("late beats cpu_ready", 32'(cpu_ready), 32'd0);
    fetch(32'h0000_03C4, 1'b1, 32'h0000_03C0, 32'h50, 32'h51, -1, -1, "refetch 3c4");
`ifdef ICACHE_STATS_EN
    check("final hit_cnt", hit_cnt, 32'd0);
    check("final miss_cnt", miss_cnt, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
